// File: rtl/sym_timing_nco.sv
// sym_timing_nco: symbol-timing NCO that strobes once per OSF-sample wrap with integer phase and fractional mu
// Ports: clk, reset (async, active-high); en_i sample valid; sync_i reloads the accumulator to 0;
//   ctrl_i/ctrl_valid_i load a signed Q.FW correction into the step register; phase_ofs_i integer offset;
//   phase_int_o/mu_o/sym_valid_o symbol strobe; sat_o step clamped; sym_cnt_o/sat_cnt_o statistics.
// Option: define SYM_NCO_STATS_EN to build the strobe and saturation counters; otherwise both read 0.
module sym_timing_nco #(
  parameter int OSF = 20,
  parameter int FW  = 27,
  parameter int IW  = 5,
  parameter int CW  = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic [CW-1:0] ctrl_i,
  input  logic          ctrl_valid_i,
  input  logic [IW-1:0] phase_ofs_i,
  output logic [IW-1:0] phase_int_o,
  output logic [FW-1:0] mu_o,
  output logic          sym_valid_o,
  output logic          sat_o,
  output logic [15:0]   sym_cnt_o,
  output logic [15:0]   sat_cnt_o
);
  localparam int AW = IW + FW;
  localparam logic [AW-1:0] MODV = AW'(OSF) << FW;
  localparam logic [AW-1:0] STEP_ONE = AW'(1) << FW;
  localparam logic signed [CW+1:0] ONE = (CW+2)'(1 << FW);
  localparam logic signed [CW+1:0] SMIN = (CW+2)'(1 << (FW-1));
  localparam logic signed [CW+1:0] SMAX = (CW+2)'(3 << (FW-1));
  logic [AW-1:0] acc, step, nxt, res, step_c;
  logic signed [CW+1:0] sum;
  logic [IW:0] psum;
  logic [IW-1:0] ph_n;
  logic lo, hi, wrap, adv;
  // Two guard bits keep 1.0 + most-positive correction from overflowing before the clamp.
  assign sum = ONE + (CW+2)'($signed(ctrl_i));
  assign lo = sum < SMIN;
  assign hi = sum > SMAX;
  assign step_c = AW'(lo ? SMIN : hi ? SMAX : sum);
  assign adv = en_i & ~sync_i;
  assign nxt = acc + step;
  assign wrap = nxt >= MODV;
  assign res = nxt - MODV;
  assign psum = {1'b0, res[AW-1:FW]} + {1'b0, phase_ofs_i};
  assign ph_n = IW'(psum >= (IW+1)'(OSF) ? psum - (IW+1)'(OSF) : psum);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      step <= STEP_ONE;
      sat_o <= 1'b0;
      sym_valid_o <= 1'b0;
      phase_int_o <= '0;
      mu_o <= '0;
    end else begin
      sym_valid_o <= adv & wrap;
      if (sync_i) acc <= '0;
      else if (en_i) acc <= wrap ? res : nxt;
      if (adv & wrap) begin
        phase_int_o <= ph_n;
        mu_o <= res[FW-1:0];
      end
      // Loaded after the accumulator uses the old step, so a coincident strobe is unaffected.
      if (ctrl_valid_i) begin
        step <= step_c;
        sat_o <= lo | hi;
      end
    end
`ifdef SYM_NCO_STATS_EN
  logic [15:0] sym_cnt, sat_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset || sync_i) begin
      sym_cnt <= '0;
      sat_cnt <= '0;
    end else begin
      if (adv & wrap) sym_cnt <= sym_cnt + 16'd1;
      if (ctrl_valid_i & (lo | hi)) sat_cnt <= sat_cnt + 16'd1;
    end
  assign sym_cnt_o = sym_cnt;
  assign sat_cnt_o = sat_cnt;
`else
  assign sym_cnt_o = '0;
  assign sat_cnt_o = '0;
`endif
  ofs_legal: assert property (@(posedge clk) disable iff (reset) phase_ofs_i < IW'(OSF));
endmodule

// File: tb/tb_sym_timing_nco.sv
// tb_sym_timing_nco: directed bench for sym_timing_nco with a sample-arithmetic reference model
module tb_sym_timing_nco;
  localparam longint ONE = 64'd1 << 27;
  localparam longint MODV = 20 * ONE;
`ifdef SYM_NCO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, en_i = 1'b0, sync_i = 1'b0, ctrl_valid_i = 1'b0;
  logic signed [27:0] ctrl_i = '0;
  logic [4:0] phase_ofs_i = '0;
  logic [4:0] phase_int_o;
  logic [26:0] mu_o;
  logic sym_valid_o, sat_o;
  logic [15:0] sym_cnt_o, sat_cnt_o;
  int checks = 0, errors = 0, g;
  bit tog = 1'b0;
  sym_timing_nco dut (
    .clk(clk), .reset(reset), .en_i(en_i), .sync_i(sync_i), .ctrl_i(ctrl_i),
    .ctrl_valid_i(ctrl_valid_i), .phase_ofs_i(phase_ofs_i), .phase_int_o(phase_int_o),
    .mu_o(mu_o), .sym_valid_o(sym_valid_o), .sat_o(sat_o), .sym_cnt_o(sym_cnt_o), .sat_cnt_o(sat_cnt_o)
  );
  always #5 clk = ~clk;
  // Reference model: phase in samples scaled by 2^27, step as a clamped sample rate.
  longint m_acc, m_step, e_ph, e_mu, nx, tc;
  bit e_vld, e_sat, wr, tsat;
  logic [15:0] e_sc, e_tc;
  assign nx = m_acc + m_step;
  assign wr = en_i && !sync_i && nx >= MODV;
  assign tc = ONE + longint'(ctrl_i);
  assign tsat = tc < ONE / 2 || tc > 3 * ONE / 2;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_acc <= 0; m_step <= ONE; e_vld <= 0; e_sat <= 0; e_ph <= 0; e_mu <= 0; e_sc <= 0; e_tc <= 0;
    end else begin
      if (sync_i) m_acc <= 0;
      else if (en_i) m_acc <= wr ? nx - MODV : nx;
      e_vld <= wr;
      if (wr) begin
        e_ph <= ((nx - MODV) / ONE + longint'(phase_ofs_i)) % 20;
        e_mu <= (nx - MODV) % ONE;
      end
      e_sc <= sync_i ? 16'd0 : wr ? e_sc + 16'd1 : e_sc;
      e_tc <= sync_i ? 16'd0 : (ctrl_valid_i && tsat) ? e_tc + 16'd1 : e_tc;
      if (ctrl_valid_i) begin
        m_step <= tc < ONE / 2 ? ONE / 2 : tc > 3 * ONE / 2 ? 3 * ONE / 2 : tc;
        e_sat <= tsat;
      end
    end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      chk("sym_valid", 64'(sym_valid_o), 64'(e_vld));
      chk("phase_int", 64'(phase_int_o), e_ph);
      chk("mu", 64'(mu_o), e_mu);
      chk("sat", 64'(sat_o), 64'(e_sat));
      chk("sym_cnt", 64'(sym_cnt_o), STATS ? 64'(e_sc) : 64'd0);
      chk("sat_cnt", 64'(sat_cnt_o), STATS ? 64'(e_tc) : 64'd0);
    end
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      if (tog) en_i = ~en_i;
      @(negedge clk);
      n++;
    end while (!sym_valid_o && n < 100);
    chk("strobe_timeout", 64'(sym_valid_o), 64'd1);
  endtask
  task automatic load(input logic signed [27:0] c, input bit s);
    ctrl_i = c; ctrl_valid_i = 1'b1; sync_i = s;
    @(negedge clk);
    ctrl_valid_i = 1'b0; sync_i = 1'b0;
  endtask
  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(sym_valid_o), 64'd0);
    chk("rst_phase", 64'(phase_int_o), 64'd0);
    chk("rst_mu", 64'(mu_o), 64'd0);
    chk("rst_sat", 64'(sat_o), 64'd0);
    chk("rst_symcnt", 64'(sym_cnt_o), 64'd0);
    reset = 1'b0; en_i = 1'b1;
    wait_strobe(g); chk("first_gap", g, 20);
    chk("t1_phase", 64'(phase_int_o), 64'd0); chk("t1_mu", 64'(mu_o), 64'd0);
    repeat (2) begin wait_strobe(g); chk("t1_gap", g, 20); end
    load(28'sd4194304, 1'b1);
    wait_strobe(g); chk("t2_gap_a", g, 20);
    chk("t2_mu_a", 64'(mu_o), 64'd83886080); chk("t2_sat", 64'(sat_o), 64'd0);
    wait_strobe(g); chk("t2_gap_b", g, 19); chk("t2_mu_b", 64'(mu_o), 64'd29360128);
    repeat (8) begin wait_strobe(g); chk("t2_gap_range", 64'(g == 19 || g == 20), 64'd1); end
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(sym_valid_o), 64'd0); chk("arst_phase", 64'(phase_int_o), 64'd0);
    chk("arst_mu", 64'(mu_o), 64'd0); chk("arst_sat", 64'(sat_o), 64'd0);
    chk("arst_symcnt", 64'(sym_cnt_o), 64'd0); chk("arst_satcnt", 64'(sat_cnt_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_strobe(g); chk("arst_gap", g, 20);
    phase_ofs_i = 5'd19;
    load(28'sd134217727, 1'b1);
    chk("t3_sat_hi", 64'(sat_o), 64'd1);
    wait_strobe(g); chk("t3_gap_a", g, 14);
    chk("t5_ofs_wrap", 64'(phase_int_o), 64'd0); chk("t3_mu_a", 64'(mu_o), 64'd0);
    wait_strobe(g); chk("t3_gap_b", g, 13);
    chk("t3_phase_b", 64'(phase_int_o), 64'd19); chk("t3_mu_b", 64'(mu_o), 64'd67108864);
    repeat (12) @(negedge clk);
    load(-28'sd134217728, 1'b0);
    chk("t5_coincide", 64'(sym_valid_o), 64'd1); chk("t5_coin_phase", 64'(phase_int_o), 64'd19);
    chk("t3_sat_lo", 64'(sat_o), 64'd1);
    phase_ofs_i = 5'd0;
    repeat (2) begin wait_strobe(g); chk("t3_gap_slow", g, 40); end
    chk("t3_satcnt", 64'(sat_cnt_o), STATS ? 64'd1 : 64'd0);
    load(28'sd0, 1'b1);
    chk("t3_sat_clear", 64'(sat_o), 64'd0);
    wait_strobe(g); chk("t4_gap_pre", g, 20);
    repeat (19) @(negedge clk);
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    chk("t4_suppress", 64'(sym_valid_o), 64'd0);
    wait_strobe(g); chk("t4_gap_post", g, 20);
    tog = 1'b1;
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    wait_strobe(g);
    repeat (2) begin wait_strobe(g); chk("t4_gap_toggle", g, 40); end
    tog = 1'b0; en_i = 1'b1;
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    repeat (100) wait_strobe(g);
    chk("t6_symcnt100", 64'(sym_cnt_o), STATS ? 64'd100 : 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
